// File: rtl/add_sum_accumulator_if.sv
// Sample/total handshake bundle between the adder stage, the accumulator and its consumer.
// The slave modport is the accumulator's view; the master modport is the driver/consumer view.
interface add_sum_accumulator_if #(
  parameter int DW    = 4,
  parameter int ACC_W = 9
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [DW:0]   in_y;

  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             out_err;
  logic [7:0]       err_cnt;
  logic [7:0]       blk_cnt;

  modport slave (
    input  in_valid, in_a, in_b, in_y, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_err, err_cnt, blk_cnt
  );

  modport master (
    output in_valid, in_a, in_b, in_y, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_err, err_cnt, blk_cnt
  );
endinterface

// File: rtl/add_sum_accumulator.sv
// Block accumulator for adder results: sums BLOCK_LEN y values and presents the total on a handshake.
// Define SUM_CHECK_EN to also cross-check each y against a+b (out_err, err_cnt); otherwise both read 0.
module add_sum_accumulator #(
  parameter int DW        = 4,
  parameter int BLOCK_LEN = 11,
  parameter int ACC_W     = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  add_sum_accumulator_if.slave  bus
);

  localparam int CNT_W = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             mism;
  logic [ACC_W-1:0] out_sum_q;
  logic             out_ovf_q;
  logic             out_err_q;
  logic [7:0]       blk_cnt_q;
  logic [7:0]       err_cnt_q;

  logic             accept;
  logic             last;
  logic             carry;
  logic             mism_now;
  logic [SUM_W-1:0] sum_ext;

  assign accept  = (state == ACCUM) && bus.in_valid;
  assign last    = (cnt == CNT_W'(BLOCK_LEN - 1));
  assign sum_ext = {1'b0, acc} + SUM_W'(bus.in_y);
  assign carry   = sum_ext[ACC_W];

`ifdef SUM_CHECK_EN
  assign mism_now = (bus.in_y != ({1'b0, bus.in_a} + {1'b0, bus.in_b}));
`else
  assign mism_now = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last) state_nxt = HOLD;
      HOLD:    if (bus.out_ready)  state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Handshake flags are pure decodes of the state register, so no input reaches them combinationally.
  always_comb begin
    bus.in_ready  = (state == ACCUM);
    bus.out_valid = (state == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      mism      <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
      out_err_q <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      if (accept) begin
        if (last) begin
          out_sum_q <= sum_ext[ACC_W-1:0];
          out_ovf_q <= ovf | carry;
          out_err_q <= mism | mism_now;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
          mism      <= 1'b0;
        end else begin
          acc  <= sum_ext[ACC_W-1:0];
          cnt  <= cnt + 1'b1;
          ovf  <= ovf | carry;
          mism <= mism | mism_now;
        end
      end
      if (state == HOLD && bus.out_ready) blk_cnt_q <= blk_cnt_q + 1'b1;
    end
  end

`ifdef SUM_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   err_cnt_q <= '0;
    else if (accept && mism_now && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
  end
`else
  assign err_cnt_q = '0;
`endif

  assign bus.out_sum = out_sum_q;
  assign bus.out_ovf = out_ovf_q;
  assign bus.out_err = out_err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.blk_cnt = blk_cnt_q;

endmodule

// File: doc/add_sum_accumulator.md
# add_sum_accumulator

Downstream consumer of the 4-bit adder stage: accepts one (a, b, y) result per valid/ready handshake, accumulates y over a fixed block of samples, and presents the block total on an output handshake. It closes the add-and-display stimulus loop with a registered, back-pressurable sink. Under a compile-time option, it also cross-checks each y against a+b.

## Interface
- DW, 4, operand width of a and b; y is DW+1 bits
- BLOCK_LEN, 11, samples per block; legal range 2..255
- ACC_W, 9, accumulator/out_sum width; total wraps modulo 2^ACC_W
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  upstream sample valid
- in_ready  output  1  block can accept a sample
- in_a  input  DW  operand a
- in_b  input  DW  operand b
- in_y  input  DW+1  adder result
- out_valid  output  1  block total valid
- out_ready  input  1  downstream accepts total
- out_sum  output  ACC_W  block total of y
- out_ovf  output  1  total exceeded 2^ACC_W-1 within the block
- out_err  output  1  one or more mismatches in the block (SUM_CHECK_EN)
- err_cnt  output  8  saturating lifetime mismatch count (SUM_CHECK_EN)
- blk_cnt  output  8  blocks delivered, wraps at 256

## Operation
- One clock (clk); reset (rst) is asynchronous, active-high.
- Two states: ACCUM and HOLD. Reset enters ACCUM.
- **Reset values:** acc=0, cnt=0, in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_err=0, err_cnt=0, blk_cnt=0.
- **ACCUM state:**
  - in_ready=1 and out_valid=0.
  - A sample is accepted when in_valid&&in_ready at a rising edge. On accept: acc<=acc+in_y, computed at ACC_W+1 bits; a carry-out sets the sticky per-block ovf bit; cnt<=cnt+1.
  - When the accept has cnt==BLOCK_LEN-1: out_sum<=acc+in_y (truncated), out_ovf<=ovf|carry, out_err<=mism|this-sample mismatch, out_valid<=1, acc/cnt/ovf/mism cleared, and the state moves to HOLD.
- **HOLD state:**
  - in_ready=0; upstream stalls.
  - out_sum, out_ovf and out_err are held stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready: out_valid<=0, blk_cnt<=blk_cnt+1, and the state returns to ACCUM.
- in_valid while in_ready=0 is ignored. Upstream holds the data; no sample is dropped or double-counted.
- Width rules:
  - in_y is zero-extended to ACC_W.
  - Default ACC_W=9 holds 11×31=341 without overflow.
  - out_ovf flags under-sized configurations.
- Reset mid-block or during HOLD: the partial sum and the pending total are discarded. Outputs take their reset values asynchronously.

## Timing
- in_ready is a registered state decode: high in ACCUM, low in HOLD.
- out_valid rises the cycle after the BLOCK_LEN-th accept, i.e. 1 cycle of latency.
- Minimum block period is BLOCK_LEN+1 cycles (BLOCK_LEN accepts plus 1 HOLD cycle with out_ready=1).
- out_ready may be high before out_valid. The handshake completes on the first edge where both are high.
- No combinational path from in_valid or out_ready to any output.

## Configuration
- **SUM_CHECK_EN defined:**
  - Every accepted sample compares in_y against the (DW+1)-bit sum in_a+in_b.
  - A mismatch sets the sticky per-block mism bit and increments err_cnt, saturating at 255.
- **SUM_CHECK_EN undefined:**
  - No comparator is built; in_a and in_b are unused.
  - out_err and err_cnt are held at 0.
  - Accumulation behaviour is identical in both builds.

## Test plan
- rst pulse mid-cycle with clk running -> all outputs at reset values immediately; in_ready=1.
- 11 samples of a=1, b=3, y=4, in_valid held high, out_ready=1 -> out_sum=44, out_ovf=0, out_err=0, out_valid high for 1 cycle, blk_cnt=1.
- 11 samples of a=15, b=15, y=30, with out_ready=0 for 5 cycles after out_valid -> in_ready=0 and out_sum=330 held stable throughout; after out_ready=1, blk_cnt increments and in_ready returns to 1.
- Build with ACC_W=8, 11 samples of y=31 -> out_sum=341 mod 256=85, out_ovf=1.
- SUM_CHECK_EN build, block containing a=5, b=6, y=10 once and the other samples correct -> out_err=1, err_cnt=1. The next fully correct block gives out_err=0 and err_cnt stays 1.
- rst asserted after 6 accepts of y=9 -> next full block of y=2 yields out_sum=22, with no carry-over from the discarded partial block.
